// File: rtl/lcd_led_pwm.sv
// lcd_led_pwm: Avalon-MM programmable PWM dimmer for the LCD board red LED.
// Takes the LED PIO on/off request and drives the pin with a dimmed,
// optionally fading waveform. Optional blink gating is compiled in only
// when the macro LCD_LED_PWM_BLINK_EN is defined.
module lcd_led_pwm #(
    parameter int PW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        led_en,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        led_pwm
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    state_t         state;
    logic [PW-1:0]  level;
    logic [PW-1:0]  duty;
    logic [15:0]    prescale;
    logic           fade;
    logic [15:0]    pre_cnt;
    logic [PW-1:0]  pwm_cnt;
    logic           tick;
    logic           pend;
    logic           gate;
    logic           wr_en;
    logic [PW:0]    level_inc;
    logic           unused_wd;

    assign wr_en     = chipselect && !write_n;
    assign tick      = (pre_cnt == prescale);
    assign pend      = tick && (pwm_cnt == '1);
    assign level_inc = {1'b0, level} + {{PW{1'b0}}, 1'b1};
    assign unused_wd = ^writedata[31:16];

`ifdef LCD_LED_PWM_BLINK_EN
    logic       blink;
    logic [7:0] blink_half;
    logic [7:0] blink_cnt;
    logic [7:0] half_eff;
    logic       phase;

    assign half_eff = (blink_half == 8'd0) ? 8'd1 : blink_half;
    assign gate     = !blink || phase;

    // Blink phase flips every max(BLINK_HALF,1) periods; parked high while blink is off
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= 8'd0;
            phase     <= 1'b1;
        end else if (!blink) begin
            blink_cnt <= 8'd0;
            phase     <= 1'b1;
        end else if (pend) begin
            if ({1'b0, blink_cnt} + 9'd1 >= {1'b0, half_eff}) begin
                blink_cnt <= 8'd0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end
`else
    assign gate = 1'b1;
`endif

    // CPU-visible control registers; STATUS is read-only so address 3 is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            fade     <= 1'b0;
            duty     <= {1'b1, {(PW-1){1'b0}}};
            prescale <= 16'd0;
`ifdef LCD_LED_PWM_BLINK_EN
            blink      <= 1'b0;
            blink_half <= 8'd0;
`endif
        end else if (wr_en) begin
            case (address)
                2'd0: begin
                    fade <= writedata[0];
`ifdef LCD_LED_PWM_BLINK_EN
                    blink      <= writedata[1];
                    blink_half <= writedata[15:8];
`endif
                end
                2'd1: duty     <= writedata[PW-1:0];
                2'd2: prescale <= writedata[15:0];
                default: ;
            endcase
        end
    end

    // Prescaler divides the clock into ticks; the PWM counter advances once per tick
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= 16'd0;
            pwm_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= 16'd0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // Fade state machine; level and state only move at period end so the output never glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OFF;
            level <= '0;
        end else if (pend) begin
            case (state)
                ST_OFF: begin
                    if (led_en) begin
                        if (fade) begin
                            state <= ST_UP;
                        end else begin
                            state <= ST_ON;
                            level <= duty;
                        end
                    end
                end
                ST_UP: begin
                    if (!fade) begin
                        state <= led_en ? ST_ON : ST_OFF;
                        level <= led_en ? duty : '0;
                    end else if (!led_en) begin
                        state <= ST_DOWN;
                    end else if (level_inc >= {1'b0, duty}) begin
                        state <= ST_ON;
                        level <= duty;
                    end else begin
                        level <= level_inc[PW-1:0];
                    end
                end
                ST_ON: begin
                    if (!led_en) begin
                        if (fade) begin
                            state <= ST_DOWN;
                        end else begin
                            state <= ST_OFF;
                            level <= '0;
                        end
                    end else begin
                        level <= duty;
                    end
                end
                ST_DOWN: begin
                    if (!fade) begin
                        state <= led_en ? ST_ON : ST_OFF;
                        level <= led_en ? duty : '0;
                    end else if (led_en) begin
                        state <= ST_UP;
                    end else if (level <= PW'(1)) begin
                        state <= ST_OFF;
                        level <= '0;
                    end else begin
                        level <= level - 1'b1;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    level <= '0;
                end
            endcase
        end
    end

    // Registered pin driver: high while the counter is below the current level
    always_ff @(posedge clk) begin
        if (reset) begin
            led_pwm <= 1'b0;
        end else begin
            led_pwm <= gate && (pwm_cnt < level);
        end
    end

    // Zero-wait-state read mux; unused bits read as zero
    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: begin
                readdata[0] = fade;
`ifdef LCD_LED_PWM_BLINK_EN
                readdata[1]    = blink;
                readdata[15:8] = blink_half;
`endif
            end
            2'd1: readdata[PW-1:0] = duty;
            2'd2: readdata[15:0]   = prescale;
            2'd3: begin
                readdata[0]    = led_en;
                readdata[1]    = led_pwm;
                readdata[3:2]  = state;
                readdata[15:8] = 8'(level);
            end
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_lcd_led_pwm.sv
// tb_lcd_led_pwm: self-checking bench for lcd_led_pwm with a period-level
// reference model; blink checks follow LCD_LED_PWM_BLINK_EN.
module tb_lcd_led_pwm;

    localparam int S_OFF  = 0;
    localparam int S_UP   = 1;
    localparam int S_ON   = 2;
    localparam int S_DOWN = 3;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        led_en     = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic        led_pwm;

    int n_compared   = 0;
    int n_mismatched = 0;
    int hi_count     = 0;

    // Reference model: position inside the period as a plain clock count
    int m_prescale, m_cip, m_level, m_state, m_duty, m_half, m_bcnt;
    bit m_fade, m_blink, m_phase, m_pwm;

    int          guard, t, first_rise, second_rise;
    logic        prev;
    logic [31:0] rd;
    int          hi_arr[8];
    int          n_active;

    lcd_led_pwm #(.PW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .led_en     (led_en),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_pwm    (led_pwm)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        m_prescale = 0; m_cip = 0; m_level = 0; m_state = S_OFF;
        m_duty = 128; m_fade = 1'b0; m_blink = 1'b0; m_half = 0;
        m_bcnt = 0; m_phase = 1'b1; m_pwm = 1'b0;
    endfunction

    function automatic void modelEdge();
        int  sub, plen, nl, ns, newp;
        bit  gate_now, pend;
        if (reset) begin
            modelReset();
            return;
        end
        sub      = m_prescale + 1;
        plen     = 256 * sub;
        gate_now = !m_blink || m_phase;
        pend     = (m_cip == plen - 1);
        nl = m_level;
        ns = m_state;
        if (pend) begin
            if (m_state == S_OFF) begin
                if (led_en) begin
                    if (m_fade) ns = S_UP;
                    else begin ns = S_ON; nl = m_duty; end
                end
            end else if (m_state == S_ON) begin
                if (!led_en) begin
                    if (m_fade) ns = S_DOWN;
                    else begin ns = S_OFF; nl = 0; end
                end else nl = m_duty;
            end else if (!m_fade) begin
                if (led_en) begin ns = S_ON; nl = m_duty; end
                else begin ns = S_OFF; nl = 0; end
            end else if (m_state == S_UP) begin
                if (!led_en) ns = S_DOWN;
                else if (m_level + 1 >= m_duty) begin ns = S_ON; nl = m_duty; end
                else nl = m_level + 1;
            end else begin
                if (led_en) ns = S_UP;
                else begin
                    nl = (m_level > 0) ? m_level - 1 : 0;
                    if (nl == 0) ns = S_OFF;
                end
            end
        end
        if (!m_blink) begin
            m_bcnt = 0; m_phase = 1'b1;
        end else if (pend) begin
            m_bcnt++;
            if (m_bcnt >= ((m_half == 0) ? 1 : m_half)) begin
                m_bcnt = 0; m_phase = !m_phase;
            end
        end
        m_pwm   = gate_now && ((m_cip / sub) < m_level);
        m_cip   = (m_cip + 1) % plen;
        m_level = nl;
        m_state = ns;
        if (chipselect && !write_n) begin
            case (address)
                2'd0: begin
                    m_fade = writedata[0];
`ifdef LCD_LED_PWM_BLINK_EN
                    m_blink = writedata[1];
                    m_half  = int'(writedata[15:8]);
`endif
                end
                2'd1: m_duty = int'(writedata[7:0]);
                2'd2: begin
                    // Only reprogrammed from zero, where the sub-tick count is 0
                    newp       = int'(writedata[15:0]);
                    m_cip      = m_cip * (newp + 1);
                    m_prescale = newp;
                end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] modelStatus();
        return {16'd0, 8'(m_level), 4'd0, 2'(m_state), m_pwm, led_en};
    endfunction

    function automatic logic [31:0] modelCtrl();
        return {16'd0, 8'(m_half), 6'd0, m_blink, m_fade};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("led_pwm", {31'd0, led_pwm}, {31'd0, m_pwm});
        if (led_pwm === 1'b1) hi_count++;
    endtask

    task automatic applyStimulus(input logic en);
        led_en = en;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic checkReg(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        checkOutput(tag, readdata, exp);
    endtask

    task automatic runToPend();
        int g;
        g = 0;
        do begin
            cycle();
            g++;
        end while (m_cip != 0 && g < 5000);
    endtask

    initial begin
        modelReset();

        // Reset held two cycles with the request high
        applyStimulus(1'b1);
        reset = 1'b1;
        cycle();
        cycle();
        checkReg(2'd3, 32'h0000_0001, "rst_status");
        checkReg(2'd1, 32'h0000_0080, "rst_duty");
        checkReg(2'd0, 32'h0000_0000, "rst_ctrl");
        checkReg(2'd2, 32'h0000_0000, "rst_prescale");
        reset = 1'b0;

        // Non-fade dimming at DUTY=64
        writeReg(2'd1, 32'd64);
        runToPend();
        runToPend();
        hi_count = 0;
        repeat (256) cycle();
        checkOutput("nonfade_high", hi_count, 32'd64);
        checkReg(2'd3, 32'h0000_4009, "nonfade_status");

        // Back to OFF, then fade up to DUTY=4
        applyStimulus(1'b0);
        runToPend();
        checkReg(2'd3, 32'h0000_0000, "off_status");
        writeReg(2'd1, 32'd4);
        writeReg(2'd0, 32'd1);
        applyStimulus(1'b1);
        runToPend(); checkReg(2'd3, 32'h0000_0005, "fade_up0");
        runToPend(); checkReg(2'd3, 32'h0000_0105, "fade_up1");
        runToPend(); checkReg(2'd3, 32'h0000_0205, "fade_up2");
        runToPend(); checkReg(2'd3, 32'h0000_0305, "fade_up3");
        runToPend(); checkReg(2'd3, 32'h0000_0409, "fade_on4");

        // Fade down from ON
        applyStimulus(1'b0);
        runToPend(); checkReg(2'd3, 32'h0000_040C, "fade_down4");
        for (int lv = 3; lv >= 1; lv--) begin
            runToPend();
            checkReg(2'd3, (32'(lv) << 8) | 32'h0C, "fade_down");
        end
        runToPend(); checkReg(2'd3, 32'h0000_0000, "fade_off");

        // Abort a fade-up at level 2
        applyStimulus(1'b1);
        runToPend(); checkReg(2'd3, 32'h0000_0005, "abort_up0");
        runToPend(); checkReg(2'd3, 32'h0000_0105, "abort_up1");
        runToPend(); checkReg(2'd3, 32'h0000_0205, "abort_up2");
        applyStimulus(1'b0);
        runToPend(); checkReg(2'd3, 32'h0000_020C, "abort_down2");
        runToPend(); checkReg(2'd3, 32'h0000_010C, "abort_down1");
        runToPend(); checkReg(2'd3, 32'h0000_0000, "abort_off");

        // STATUS is read-only; CTRL blink bits depend on the build
        writeReg(2'd3, 32'h0000_FFFF);
        checkReg(2'd3, 32'h0000_0000, "bus_status_ro");
        checkReg(2'd1, 32'h0000_0004, "bus_duty");
        checkReg(2'd0, 32'h0000_0001, "bus_ctrl");
        checkReg(2'd2, 32'h0000_0000, "bus_prescale");
        writeReg(2'd0, 32'hFFFF_FF03);
`ifdef LCD_LED_PWM_BLINK_EN
        checkReg(2'd0, 32'h0000_FF03, "ctrl_blink_rw");
`else
        checkReg(2'd0, 32'h0000_0001, "ctrl_blink_ro");
`endif
        writeReg(2'd0, 32'd1);

        // Randomized periods against the reference model
        for (int p = 0; p < 24; p++) begin
            case ($urandom_range(0, 3))
                0:       rd = 32'd0;
                1:       rd = 32'd255;
                default: rd = 32'($urandom_range(1, 254));
            endcase
            writeReg(2'd1, rd);
            if ($urandom_range(0, 1) == 1) writeReg(2'd0, $urandom);
            guard = 0;
            while (m_cip != 0 && guard < 2000) begin
                if ($urandom_range(0, 149) == 0) applyStimulus(!led_en);
                if ($urandom_range(0, 199) == 0)
                    writeReg(($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3, $urandom);
                else
                    cycle();
                guard++;
            end
            checkReg(2'd3, modelStatus(), "rand_status");
            checkReg(2'd0, modelCtrl(), "rand_ctrl");
            checkReg(2'd1, 32'(m_duty), "rand_duty");
        end

        // Prescale 3: 1024-clock period, DUTY change deferred to period end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        writeReg(2'd1, 32'd128);
        writeReg(2'd0, 32'd0);
        applyStimulus(1'b1);
        writeReg(2'd2, 32'd3);
        checkReg(2'd2, 32'h0000_0003, "pre_readback");
        runToPend();
        runToPend();
        hi_count = 0;
        repeat (1024) cycle();
        checkOutput("pre_high128", hi_count, 32'd512);
        checkReg(2'd3, 32'h0000_8009, "pre_status128");
        hi_count = 0;
        repeat (300) cycle();
        writeReg(2'd1, 32'd32);
        repeat (723) cycle();
        checkOutput("duty_mid_hold", hi_count, 32'd512);
        hi_count = 0;
        repeat (1024) cycle();
        checkOutput("duty_next_period", hi_count, 32'd128);
        checkReg(2'd3, 32'h0000_2009, "pre_status32");
        t = 0; first_rise = -1; second_rise = -1;
        prev = led_pwm;
        for (int i = 0; i < 2200 && second_rise < 0; i++) begin
            cycle();
            t++;
            if (led_pwm === 1'b1 && prev === 1'b0) begin
                if (first_rise < 0) first_rise = t;
                else second_rise = t;
            end
            prev = led_pwm;
        end
        checkOutput("pre_period", 32'(second_rise - first_rise), 32'd1024);

`ifdef LCD_LED_PWM_BLINK_EN
        // Blink with half period 2 at full duty
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        writeReg(2'd1, 32'd255);
        writeReg(2'd0, 32'h0000_0202);
        applyStimulus(1'b1);
        runToPend();
        runToPend();
        n_active = 0;
        for (int i = 0; i < 8; i++) begin
            hi_count = 0;
            repeat (256) cycle();
            hi_arr[i] = hi_count;
            if (hi_count == 255) n_active++;
        end
        checkOutput("blink_active", n_active, 32'd4);
        for (int i = 0; i < 6; i++)
            checkOutput("blink_alt", {31'd0, hi_arr[i] != 0}, {31'd0, hi_arr[i+2] == 0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/lcd_led_pwm.md
# lcd_led_pwm

Avalon-MM-programmable PWM dimmer for the LCD board's red LED. It sits directly downstream of the single-bit LED PIO: it consumes the PIO's `out_port` as an on/off request and drives the physical pin with a dimmed waveform. The waveform can optionally fade in and out, and can optionally blink. A CPU-side Avalon slave exposes the duty, prescale and control registers.

## Interface
Parameters:
- `PW`, 8: PWM counter and level width. This spec is written for 8; all values below assume `PW=8`.

Ports:
- `clk`, in, 1: single system clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `led_en`, in, 1: on/off request from the LED PIO `out_port`. It is in the same clock domain, so no synchronizer is used.
- `address`, in, 2: Avalon register select.
- `chipselect`, in, 1: Avalon select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: combinational function of `address`; zero wait states.
- `led_pwm`, out, 1: registered PWM output to the pin.

## Operation
- A write occurs when `chipselect && !write_n`. Unused bits read as 0.
- Register map:
  - addr 0, CTRL: bit0 FADE, bit1 BLINK, [15:8] BLINK_HALF. Reset value 0.
  - addr 1, DUTY: [7:0]. Reset value 0x80.
  - addr 2, PRESCALE: [15:0]. Reset value 0.
  - addr 3, STATUS, read-only, writes ignored: bit0 `led_en`, bit1 `led_pwm`, [3:2] state, [15:8] level.
- Prescaler: `pre_cnt` counts 0..PRESCALE. `tick` asserts when `pre_cnt==PRESCALE`, then `pre_cnt` returns to 0.
- PWM counter: `pwm_cnt` increments on `tick` and wraps 255→0.
- Period end: `pend = tick && pwm_cnt==255`.
- Output: `led_pwm <= gate && (pwm_cnt < level)`.
  - level 0 gives constant low.
  - level 255 gives 255/256 high.
- `level` and `state` change only on `pend`, so the output never glitches mid-period.
- State machine (encoding OFF=0, UP=1, ON=2, DOWN=3), evaluated on `pend`:
  - OFF: if `led_en`, go to UP when FADE=1; otherwise go to ON with level←DUTY.
  - UP: if `!led_en`, go to DOWN with level unchanged. Else level←level+1; if level+1≥DUTY, set level←DUTY and go to ON.
  - ON: if `!led_en`, go to DOWN when FADE=1; otherwise go to OFF with level←0. Else level←DUTY, so DUTY changes take effect at the next period.
  - DOWN: if `led_en`, go to UP. Else level←level−1; when the result reaches 0, go to OFF.
- FADE cleared while in UP or DOWN: the next `pend` applies the non-fade rule, i.e. jump to ON with DUTY, or to OFF with 0.
- DUTY=0 while `led_en`=1: the block goes to ON with level 0, and the output stays low.
- A write to PRESCALE takes effect immediately. If `pre_cnt` is greater than the new value, `pre_cnt` wraps through 0xFFFF; this is allowed and needs no special handling.

## Timing
- Reset, checked in the cycle after `reset` is sampled high:
  - `led_pwm`=0, state OFF, level 0, all counters 0.
  - CTRL, DUTY and PRESCALE return to their reset values.
  - `readdata` at addr 0 = 0, at addr 1 = 0x80.
- Reset mid-fade or mid-blink aborts immediately; no partial level is retained.
- PWM period is 256×(PRESCALE+1) clocks.
- Response to `led_en` rising (FADE=0): worst case, the new level applies at the first `pend` at or after the cycle in which `led_en` is sampled. `led_pwm` then rises one clock after that `pend`, because the output is registered.
- Fade from 0 to DUTY=D takes D periods.
- Register writes are visible on `readdata` in the next cycle.

## Configuration
- `LCD_LED_PWM_BLINK_EN` defined:
  - A blink counter counts `pend` events. Every max(BLINK_HALF,1) periods it toggles `phase`.
  - gate = !BLINK || phase.
  - `phase` resets to 1, and is forced to 1 with the counter cleared while BLINK=0.
  - Blink gates the output only; it does not affect level or state.
- `LCD_LED_PWM_BLINK_EN` undefined:
  - gate=1 and no blink logic is synthesized.
  - CTRL bit1 and bits [15:8] read 0, and writes to them are ignored.

## Test plan
- Reset: assert `reset` for 2 cycles with `led_en`=1 → `led_pwm`=0, STATUS=0x0001, addr 1 reads 0x80.
- Non-fade: PRESCALE=0, DUTY=64, FADE=0, raise `led_en` → after the first `pend`, `led_pwm` is high for exactly 64 of every 256 clocks. State reads ON (STATUS[3:2]=2).
- Fade: DUTY=4, FADE=1, raise `led_en` → level reads 1,2,3,4 on successive periods, then state ON. Drop `led_en` at level 2 in UP → DOWN, then level 1, 0, then OFF.
- Prescale: PRESCALE=3, DUTY=128 → period 1024 clocks with 512 high. Writing DUTY=32 mid-period takes effect only at the next `pend`.
- Blink (macro on): BLINK=1, BLINK_HALF=2, DUTY=255 → output alternates 2 periods active and 2 periods low. With the macro off, CTRL reads back bit1=0.
- Bus: write 0xFFFF to STATUS → no change; read back exactly as before the write.
